// File: rtl/dec_stage_pipe_if.sv
// Decode-stage port bundle: fetch handshake and instruction, WB write port,
// and the registered operand/control word presented to EX.
interface dec_stage_pipe_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
);
    localparam int unsigned AW = $clog2(NREGS);

    logic              InValid;
    logic              InReady;
    logic [31:0]       Instruction;
    logic              Flush;
    logic              RegWriteIn;
    logic [AW-1:0]     RAddrIn;
    logic [DATA_W-1:0] RData;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] RsData;
    logic [DATA_W-1:0] RtData;
    logic [AW-1:0]     RsAddr;
    logic [AW-1:0]     RtAddr;
    logic [AW-1:0]     RAddrOut;
    logic [DATA_W-1:0] ImmData;
    logic              RegDst;
    logic              Branch;
    logic              Jump;
    logic              MemRead;
    logic              MemtoReg;
    logic              MemWrite;
    logic              ALUSrc;
    logic              RegWriteOut;
    logic [5:0]        ALUfunc;
    logic [4:0]        Shamt;

    // Decode stage side
    modport slave (
        input  InValid, Instruction, Flush, RegWriteIn, RAddrIn, RData, OutReady,
        output InReady, OutValid, RsData, RtData, RsAddr, RtAddr, RAddrOut, ImmData,
               RegDst, Branch, Jump, MemRead, MemtoReg, MemWrite, ALUSrc, RegWriteOut,
               ALUfunc, Shamt
    );

    // Fetch / WB / EX side
    modport master (
        output InValid, Instruction, Flush, RegWriteIn, RAddrIn, RData, OutReady,
        input  InReady, OutValid, RsData, RtData, RsAddr, RtAddr, RAddrOut, ImmData,
               RegDst, Branch, Jump, MemRead, MemtoReg, MemWrite, ALUSrc, RegWriteOut,
               ALUfunc, Shamt
    );
endinterface

// File: rtl/dec_stage_pipe.sv
// Registered decode stage: register file with write-through bypass, control decode,
// valid/ready output register with load-use bubble insertion and flush.
module dec_stage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32
) (
    input  logic           Clock,
    input  logic           nReset,
    dec_stage_pipe_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [5:0] alu_func;
    } ctrl_t;

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];

    logic              out_valid_q, out_valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [AW-1:0]     rs_addr_q, rs_addr_d;
    logic [AW-1:0]     rt_addr_q, rt_addr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [4:0]        shamt_q, shamt_d;

    logic [5:0]        opcode_c;
    logic [AW-1:0]     rs_c, rt_c, rd_c;
    ctrl_t             dec_c;
    logic [DATA_W-1:0] imm_c;
    logic [DATA_W-1:0] rs_val_c, rt_val_c;
    logic              uses_rt_c, hazard_c, in_ready_c, accept_c;

    // Control word and immediate for the instruction currently presented by fetch
    always_comb begin : decode
        opcode_c = bus.Instruction[31:26];
        rs_c     = AW'(bus.Instruction[25:21]);
        rt_c     = AW'(bus.Instruction[20:16]);
        dec_c    = '0;
        case (opcode_c)
            OP_RTYPE: begin
                dec_c.reg_dst   = 1'b1;
                dec_c.reg_write = 1'b1;
                dec_c.alu_func  = bus.Instruction[5:0];
            end
            OP_ADDI, OP_LUI: begin
                dec_c.alu_src   = 1'b1;
                dec_c.reg_write = 1'b1;
                dec_c.alu_func  = FN_ADD;
            end
            OP_LW: begin
                dec_c.alu_src    = 1'b1;
                dec_c.mem_read   = 1'b1;
                dec_c.mem_to_reg = 1'b1;
                dec_c.reg_write  = 1'b1;
                dec_c.alu_func   = FN_ADD;
            end
            OP_SW: begin
                dec_c.alu_src   = 1'b1;
                dec_c.mem_write = 1'b1;
                dec_c.alu_func  = FN_ADD;
            end
            OP_BEQ: begin
                dec_c.branch   = 1'b1;
                dec_c.alu_func = FN_SUB;
            end
            OP_J: begin
                dec_c.jump = 1'b1;
            end
            default: ;
        endcase
        if (opcode_c == OP_LUI) begin
            imm_c = DATA_W'($signed({bus.Instruction[15:0], 16'h0000}));
        end else begin
            imm_c = DATA_W'($signed(bus.Instruction[15:0]));
        end
        rd_c = dec_c.reg_dst ? AW'(bus.Instruction[15:11]) : rt_c;
    end

    // Operand reads; a same-cycle WB write to the read address wins, r0 is always zero
    always_comb begin : rf_read
        rs_val_c = rf_q[rs_c];
        rt_val_c = rf_q[rt_c];
        if (bus.RegWriteIn && (bus.RAddrIn == rs_c)) rs_val_c = bus.RData;
        if (bus.RegWriteIn && (bus.RAddrIn == rt_c)) rt_val_c = bus.RData;
        if (rs_c == '0) rs_val_c = '0;
        if (rt_c == '0) rt_val_c = '0;
    end

    // Load in the output register whose result the incoming instruction consumes
    always_comb begin : load_use
        uses_rt_c  = (opcode_c == OP_RTYPE) || (opcode_c == OP_SW) || (opcode_c == OP_BEQ);
        hazard_c   = out_valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                     ((rd_q == rs_c) || ((rd_q == rt_c) && uses_rt_c));
        in_ready_c = (!out_valid_q || bus.OutReady) && !hazard_c;
        accept_c   = bus.InValid && in_ready_c;
    end

    always_comb begin : rf_next
        rf_d = rf_q;
        if (bus.RegWriteIn && (bus.RAddrIn != '0)) rf_d[bus.RAddrIn] = bus.RData;
    end

    // Flush beats load; an empty or drained register without a new load becomes a NOP bubble
    always_comb begin : out_next
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_d        = rd_q;
        shamt_d     = shamt_q;
        if (bus.Flush) begin
            out_valid_d = 1'b0;
            ctrl_d      = '0;
        end else if (accept_c) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec_c;
            rs_data_d   = rs_val_c;
            rt_data_d   = rt_val_c;
            imm_d       = imm_c;
            rs_addr_d   = rs_c;
            rt_addr_d   = rt_c;
            rd_d        = rd_c;
            shamt_d     = bus.Instruction[10:6];
        end else if (bus.OutReady || !out_valid_q) begin
            out_valid_d = 1'b0;
            ctrl_d      = '0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin : out_regs
        if (!nReset) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_q        <= '0;
            shamt_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_q        <= rd_d;
            shamt_q     <= shamt_d;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin : rf_regs
        if (!nReset) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    assign bus.InReady     = in_ready_c;
    assign bus.OutValid    = out_valid_q;
    assign bus.RsData      = rs_data_q;
    assign bus.RtData      = rt_data_q;
    assign bus.RsAddr      = rs_addr_q;
    assign bus.RtAddr      = rt_addr_q;
    assign bus.RAddrOut    = rd_q;
    assign bus.ImmData     = imm_q;
    assign bus.RegDst      = ctrl_q.reg_dst;
    assign bus.Branch      = ctrl_q.branch;
    assign bus.Jump        = ctrl_q.jump;
    assign bus.MemRead     = ctrl_q.mem_read;
    assign bus.MemtoReg    = ctrl_q.mem_to_reg;
    assign bus.MemWrite    = ctrl_q.mem_write;
    assign bus.ALUSrc      = ctrl_q.alu_src;
    assign bus.RegWriteOut = ctrl_q.reg_write;
    assign bus.ALUfunc     = ctrl_q.alu_func;
    assign bus.Shamt       = shamt_q;

endmodule

// File: tb/tb_dec_stage_pipe.sv
// Bench for dec_stage_pipe: directed scenarios plus randomized traffic against an
// instruction-level reference model; a second 64-bit/16-register instance checks sign extension.
module tb_dec_stage_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    always #5 clk = ~clk;

    dec_stage_pipe_if #(.DATA_W(32), .NREGS(32)) a_if ();
    dec_stage_pipe_if #(.DATA_W(64), .NREGS(16)) b_if ();

    dec_stage_pipe #(.DATA_W(32), .NREGS(32)) dut_a (.Clock(clk), .nReset(rst_n), .bus(a_if));
    dec_stage_pipe #(.DATA_W(64), .NREGS(16)) dut_b (.Clock(clk), .nReset(rst_n), .bus(b_if));

    // Reference model: architectural registers plus the instruction sitting in front of EX
    logic [31:0] rf [32];
    logic        m_valid;
    logic [31:0] m_rs_data, m_rt_data, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
    logic [7:0]  m_ctl;   // {RegDst,Branch,Jump,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite}
    logic [5:0]  m_func;

    function automatic logic [7:0] ref_ctl(input logic [31:0] ins);
        case (ins[31:26])
            6'h00:        return 8'b1000_0001;
            6'h08, 6'h0F: return 8'b0000_0011;
            6'h23:        return 8'b0001_1011;
            6'h2B:        return 8'b0000_0110;
            6'h04:        return 8'b0100_0000;
            6'h02:        return 8'b0010_0000;
            default:      return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [5:0] ref_func(input logic [31:0] ins);
        case (ins[31:26])
            6'h00:                      return ins[5:0];
            6'h08, 6'h0F, 6'h23, 6'h2B: return 6'h20;
            6'h04:                      return 6'h22;
            default:                    return 6'h00;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (a_if.RegWriteIn && (a_if.RAddrIn == a)) return a_if.RData;
        return rf[a];
    endfunction

    // Stall if the pending load's destination is read by the presented instruction
    function automatic logic ref_ready();
        logic [5:0] op;
        logic       reads_rt, dep;
        op       = a_if.Instruction[31:26];
        reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
        dep      = (a_if.Instruction[25:21] == m_rd) || (reads_rt && (a_if.Instruction[20:16] == m_rd));
        return (!m_valid || a_if.OutReady) && !(m_valid && m_ctl[4] && (m_rd != 5'd0) && dep);
    endfunction

    function automatic logic [7:0] a_ctl();
        return {a_if.RegDst, a_if.Branch, a_if.Jump, a_if.MemRead, a_if.MemtoReg,
                a_if.MemWrite, a_if.ALUSrc, a_if.RegWriteOut};
    endfunction

    function automatic logic [130:0] a_outs();
        return {a_if.OutValid, a_if.RsData, a_if.RtData, a_if.RsAddr, a_if.RtAddr,
                a_if.RAddrOut, a_if.ImmData, a_ctl(), a_if.ALUfunc, a_if.Shamt};
    endfunction

    function automatic logic [130:0] m_outs();
        return {m_valid, m_rs_data, m_rt_data, m_rs, m_rt, m_rd, m_imm, m_ctl, m_func, m_shamt};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          k;
        ins = $urandom;
        k   = $urandom_range(0, 8);
        case (k)
            0:       ins[31:26] = 6'h00;
            1:       ins[31:26] = 6'h08;
            2:       ins[31:26] = 6'h0F;
            3, 4:    ins[31:26] = 6'h23;
            5:       ins[31:26] = 6'h2B;
            6:       ins[31:26] = 6'h04;
            7:       ins[31:26] = 6'h02;
            default: ins[31:26] = 6'($urandom);
        endcase
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        m_valid = 1'b0; m_rs_data = '0; m_rt_data = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_shamt = '0; m_ctl = '0; m_func = '0;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic fl, input logic ordy);
        a_if.InValid = v; a_if.Instruction = ins; a_if.Flush = fl; a_if.OutReady = ordy;
        a_if.RegWriteIn = 1'b0; a_if.RAddrIn = '0; a_if.RData = '0;
    endtask

    // One clock: evaluate the model on the current inputs, advance, return at edge+1
    task automatic step();
        logic        acc, wb, nv;
        logic [4:0]  wa, nrsa, nrta, nrd, nsh;
        logic [31:0] wd, ins, nrs, nrt, nimm;
        logic [7:0]  nctl;
        logic [5:0]  nfn;
        ins  = a_if.Instruction;
        acc  = a_if.InValid && ref_ready();
        wb   = a_if.RegWriteIn && (a_if.RAddrIn != 5'd0);
        wa   = a_if.RAddrIn; wd = a_if.RData;
        nv   = m_valid; nrs = m_rs_data; nrt = m_rt_data; nimm = m_imm;
        nrsa = m_rs; nrta = m_rt; nrd = m_rd; nsh = m_shamt; nctl = m_ctl; nfn = m_func;
        if (a_if.Flush) begin
            nv = 1'b0; nctl = '0;
        end else if (acc) begin
            nv   = 1'b1;
            nctl = ref_ctl(ins);
            nfn  = ref_func(ins);
            nrsa = ins[25:21];
            nrta = ins[20:16];
            nrs  = ref_read(nrsa);
            nrt  = ref_read(nrta);
            nrd  = nctl[7] ? ins[15:11] : ins[20:16];
            nimm = (ins[31:26] == 6'h0F) ? {ins[15:0], 16'h0000} : {{16{ins[15]}}, ins[15:0]};
            nsh  = ins[10:6];
        end else if (a_if.OutReady || !m_valid) begin
            nv = 1'b0; nctl = '0;
        end
        @(posedge clk);
        if (rst_n) begin
            m_valid = nv; m_rs_data = nrs; m_rt_data = nrt; m_imm = nimm; m_rs = nrsa;
            m_rt = nrta; m_rd = nrd; m_shamt = nsh; m_ctl = nctl; m_func = nfn;
            if (wb) rf[wa] = wd;
        end
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if (a_outs() !== 131'd0) begin n_err++; $display("FAIL reset_outs: got %h want 0", a_outs()); end
        n_cmp++; if (a_if.InReady !== 1'b1) begin n_err++; $display("FAIL reset_inready: got %b want 1", a_if.InReady); end
        n_cmp++; if (b_if.OutValid !== 1'b0) begin n_err++; $display("FAIL reset_b_valid: got %b want 0", b_if.OutValid); end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        drive(1'b1, 32'h2001FFFF, 1'b0, 1'b1); #1;
        n_cmp++; if (a_if.InReady !== 1'b1) begin n_err++; $display("FAIL addi_inready: got %b want 1", a_if.InReady); end
        step();
        n_cmp++; if (a_if.OutValid !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %b want 1", a_if.OutValid); end
        n_cmp++; if (a_if.ImmData !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addi_imm: got %h want ffffffff", a_if.ImmData); end
        n_cmp++; if (a_if.RAddrOut !== 5'd1) begin n_err++; $display("FAIL addi_rd: got %0d want 1", a_if.RAddrOut); end
        n_cmp++; if (a_ctl() !== 8'b0000_0011) begin n_err++; $display("FAIL addi_ctl: got %b want 00000011", a_ctl()); end
        n_cmp++; if (a_if.ALUfunc !== 6'h20) begin n_err++; $display("FAIL addi_func: got %h want 20", a_if.ALUfunc); end
    endtask

    task automatic test_lui_bypass();
        drive(1'b1, 32'h3C021234, 1'b0, 1'b1); #1; step();
        n_cmp++; if (a_if.ImmData !== 32'h12340000) begin n_err++; $display("FAIL lui_imm: got %h want 12340000", a_if.ImmData); end
        n_cmp++; if (a_if.RAddrOut !== 5'd2) begin n_err++; $display("FAIL lui_rd: got %0d want 2", a_if.RAddrOut); end
        drive(1'b1, 32'h00602020, 1'b0, 1'b1);
        a_if.RegWriteIn = 1'b1; a_if.RAddrIn = 5'd3; a_if.RData = 32'hDEADBEEF; #1; step();
        n_cmp++; if (a_if.RsData !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_rs: got %h want deadbeef", a_if.RsData); end
        n_cmp++; if ({a_if.RtData, a_if.RAddrOut, a_if.RegDst} !== {32'd0, 5'd4, 1'b1}) begin
            n_err++; $display("FAIL add_fields: got rt=%h rd=%0d regdst=%b want 0/4/1", a_if.RtData, a_if.RAddrOut, a_if.RegDst); end
        drive(1'b1, 32'h00032020, 1'b0, 1'b1);
        a_if.RegWriteIn = 1'b1; a_if.RAddrIn = 5'd0; a_if.RData = 32'h12345678; #1; step();
        n_cmp++; if ({a_if.RsData, a_if.RtData} !== {32'd0, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL r0_bypass: got rs=%h rt=%h want 0/deadbeef", a_if.RsData, a_if.RtData); end
        drive(1'b1, 32'h00002820, 1'b0, 1'b1); #1; step();
        n_cmp++; if (a_if.RsData !== 32'd0) begin n_err++; $display("FAIL r0_read: got %h want 0", a_if.RsData); end
    endtask

    task automatic test_load_use();
        drive(1'b0, 32'd0, 1'b0, 1'b1); #1; step();
        drive(1'b1, 32'h8C050000, 1'b0, 1'b1); #1; step();
        n_cmp++; if ({a_if.OutValid, a_if.MemRead, a_if.RAddrOut} !== {1'b1, 1'b1, 5'd5}) begin
            n_err++; $display("FAIL lw_issue: got v=%b mr=%b rd=%0d want 1/1/5", a_if.OutValid, a_if.MemRead, a_if.RAddrOut); end
        drive(1'b1, 32'h00A53020, 1'b0, 1'b1); #1;
        n_cmp++; if (a_if.InReady !== 1'b0) begin n_err++; $display("FAIL hazard_stall: got %b want 0", a_if.InReady); end
        step();
        n_cmp++; if ({a_if.OutValid, a_ctl()} !== 9'd0) begin
            n_err++; $display("FAIL bubble: got v=%b ctl=%b want 0/0", a_if.OutValid, a_ctl()); end
        #1;
        n_cmp++; if (a_if.InReady !== 1'b1) begin n_err++; $display("FAIL after_bubble_ready: got %b want 1", a_if.InReady); end
        step();
        n_cmp++; if ({a_if.OutValid, a_if.RAddrOut, a_if.RegDst} !== {1'b1, 5'd6, 1'b1}) begin
            n_err++; $display("FAIL add_after_lw: got v=%b rd=%0d want 1/6", a_if.OutValid, a_if.RAddrOut); end
        drive(1'b1, 32'h8C050000, 1'b0, 1'b1); #1; step();
        drive(1'b1, 32'h20E60001, 1'b0, 1'b1); #1;
        n_cmp++; if (a_if.InReady !== 1'b1) begin n_err++; $display("FAIL no_hazard_ready: got %b want 1", a_if.InReady); end
        step();
        n_cmp++; if ({a_if.OutValid, a_if.RAddrOut, a_if.ImmData} !== {1'b1, 5'd6, 32'd1}) begin
            n_err++; $display("FAIL addi_after_lw: got v=%b rd=%0d imm=%h want 1/6/1", a_if.OutValid, a_if.RAddrOut, a_if.ImmData); end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h20010005, 1'b0, 1'b1); #1; step();
        drive(1'b1, 32'h20020007, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (a_if.InReady !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0", i, a_if.InReady); end
            step();
            n_cmp++; if ({a_if.OutValid, a_if.ImmData, a_if.RAddrOut} !== {1'b1, 32'd5, 5'd1}) begin
                n_err++; $display("FAIL stall_hold[%0d]: got v=%b imm=%h rd=%0d want 1/5/1", i, a_if.OutValid, a_if.ImmData, a_if.RAddrOut); end
        end
        a_if.OutReady = 1'b1; #1;
        n_cmp++; if (a_if.InReady !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", a_if.InReady); end
        step();
        n_cmp++; if ({a_if.OutValid, a_if.ImmData, a_if.RAddrOut} !== {1'b1, 32'd7, 5'd2}) begin
            n_err++; $display("FAIL release_issue: got v=%b imm=%h rd=%0d want 1/7/2", a_if.OutValid, a_if.ImmData, a_if.RAddrOut); end
        drive(1'b0, 32'd0, 1'b0, 1'b1); #1; step();
        n_cmp++; if (a_if.OutValid !== 1'b0) begin n_err++; $display("FAIL no_duplicate: got %b want 0", a_if.OutValid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h10220004, 1'b0, 1'b1); #1; step();
        n_cmp++; if ({a_if.Branch, a_if.ALUfunc} !== {1'b1, 6'h22}) begin
            n_err++; $display("FAIL beq_issue: got br=%b fn=%h want 1/22", a_if.Branch, a_if.ALUfunc); end
        drive(1'b1, 32'hAC230008, 1'b1, 1'b1); #1;
        n_cmp++; if (a_if.InReady !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", a_if.InReady); end
        step();
        n_cmp++; if ({a_if.OutValid, a_ctl()} !== 9'd0) begin
            n_err++; $display("FAIL flush_kill: got v=%b ctl=%b want 0/0", a_if.OutValid, a_ctl()); end
        drive(1'b0, 32'd0, 1'b0, 1'b1); #1; step();
        n_cmp++; if (a_if.OutValid !== 1'b0) begin n_err++; $display("FAIL sw_dropped: got %b want 0", a_if.OutValid); end
    endtask

    task automatic test_random();
        logic exp_r;
        for (int i = 0; i < 400; i++) begin
            a_if.InValid     = ($urandom_range(0, 3) != 0);
            a_if.Instruction = rand_instr();
            a_if.Flush       = ($urandom_range(0, 9) == 0);
            a_if.OutReady    = ($urandom_range(0, 9) < 7);
            a_if.RegWriteIn  = 1'($urandom_range(0, 1));
            a_if.RAddrIn     = 5'($urandom_range(0, 7));
            a_if.RData       = $urandom;
            #1;
            exp_r = ref_ready();
            n_cmp++; if (a_if.InReady !== exp_r) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, a_if.InReady, exp_r); end
            step();
            n_cmp++;
            if (a_if.OutValid !== m_valid) begin
                n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, a_if.OutValid, m_valid);
            end else if (m_valid && (a_outs() !== m_outs())) begin
                n_err++; $display("FAIL rnd_outs[%0d]: got %h want %h", i, a_outs(), m_outs());
            end else if (!m_valid && (a_ctl() !== 8'd0)) begin
                n_err++; $display("FAIL rnd_bubble_ctl[%0d]: got %b want 0", i, a_ctl());
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        a_if.RegWriteIn = 1'b1; a_if.RAddrIn = 5'd3; a_if.RData = 32'h55AA55AA; #1; step();
        drive(1'b1, 32'h00612020, 1'b0, 1'b1); #1; step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_outs() !== 131'd0) begin n_err++; $display("FAIL midreset_outs: got %h want 0", a_outs()); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h00612020, 1'b0, 1'b1); #1; step();
        n_cmp++; if ({a_if.OutValid, a_if.RsData, a_if.RtData} !== {1'b1, 64'd0}) begin
            n_err++; $display("FAIL midreset_rf: got v=%b rs=%h rt=%h want 1/0/0", a_if.OutValid, a_if.RsData, a_if.RtData); end
    endtask

    task automatic test_wide();
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        b_if.InValid = 1'b1; b_if.Instruction = 32'h2011FFFF; #1; step();
        n_cmp++; if ({b_if.OutValid, b_if.ImmData, b_if.RAddrOut} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1}) begin
            n_err++; $display("FAIL wide_addi: got v=%b imm=%h rd=%0d want 1/ffffffffffffffff/1", b_if.OutValid, b_if.ImmData, b_if.RAddrOut); end
        b_if.Instruction = 32'h3C028000; #1; step();
        n_cmp++; if (b_if.ImmData !== 64'hFFFF_FFFF_8000_0000) begin
            n_err++; $display("FAIL wide_lui_neg: got %h want ffffffff80000000", b_if.ImmData); end
        b_if.Instruction = 32'h3C021234; #1; step();
        n_cmp++; if (b_if.ImmData !== 64'h0000_0000_1234_0000) begin
            n_err++; $display("FAIL wide_lui_pos: got %h want 0000000012340000", b_if.ImmData); end
        b_if.InValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        b_if.InValid = 1'b0; b_if.Instruction = '0; b_if.Flush = 1'b0; b_if.OutReady = 1'b1;
        b_if.RegWriteIn = 1'b0; b_if.RAddrIn = '0; b_if.RData = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_addi();
        test_lui_bypass();
        test_load_use();
        test_stall();
        test_flush();
        test_random();
        test_reset_mid();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dec_stage_pipe.md
Name: dec_stage_pipe

Overview:
Parametrised, registered decode stage for the five-stage RISC pipeline. It holds the register file with write-through bypass and decodes the control word. It also registers all decode outputs behind a valid/ready handshake and generates the load-use bubble itself, so EX sees a clean, stallable pipeline register. It sits between the fetch pipeline register and EX, and takes its write-back port from WB.

Parameters:
DATA_W, 32, datapath width; legal values are >=32. Instruction width is fixed at 32.
NREGS, 32, number of architectural registers (power of two, >=2). AW = log2(NREGS); register 0 is hardwired to zero.

Ports:
Clock  in  1  pipeline clock, rising edge
nReset  in  1  asynchronous active-low reset
InValid  in  1  fetch presents Instruction
InReady  out  1  stage accepts Instruction this cycle
Instruction  in  32  MIPS-format instruction
Flush  in  1  kill the registered output (taken branch/jump)
RegWriteIn  in  1  write-back enable
RAddrIn  in  AW  write-back address
RData  in  DATA_W  write-back data
OutValid  out  1  output register holds a live instruction
OutReady  in  1  EX consumes the output register
RsData, RtData  out  DATA_W  operand data
RsAddr, RtAddr  out  AW  operand addresses (for EX forwarding)
RAddrOut  out  AW  destination: rd if RegDst, else rt
ImmData  out  DATA_W  immediate, sign-extended or LUI-shifted
RegDst, Branch, Jump, MemRead, MemtoReg, MemWrite, ALUSrc, RegWriteOut  out  1 each  control word
ALUfunc  out  6  function code passed to EX
Shamt  out  5  Instruction[10:6]

Behaviour:
- Decode table (opcode): 0x00 R-type: RegDst, RegWrite, ALUfunc=Instruction[5:0]. 0x08 ADDI: ALUSrc, RegWrite, ALUfunc=0x20. 0x0F LUI: ALUSrc, RegWrite, ALUfunc=0x20, shifted immediate. 0x23 LW: ALUSrc, MemRead, MemtoReg, RegWrite, ALUfunc=0x20. 0x2B SW: ALUSrc, MemWrite, ALUfunc=0x20. 0x04 BEQ: Branch, ALUfunc=0x22. 0x02 J: Jump. Any other opcode decodes as a NOP: all control bits 0, ALUfunc=0.
- Immediate:
  - Non-LUI: Instruction[15:0] sign-extended to DATA_W.
  - LUI: {Instruction[15:0],16'h0}, sign-extended from bit 31 when DATA_W>32.
- Register file:
  - NREGS x DATA_W; written on the rising edge when RegWriteIn and RAddrIn!=0.
  - Reads are combinational, with write-through: if RegWriteIn and RAddrIn equals a nonzero read address, that read returns RData in the same cycle.
  - Address 0 always reads 0.
- Rs/Rt addresses are Instruction[25:21] and [20:16], truncated to AW bits.
- Output register: every output except InReady is registered. It loads when InValid && InReady.
- Latency is one cycle from acceptance to OutValid.
- Load-use hazard:
  - hazard = OutValid && MemRead(q) && RAddrOut(q)!=0 && (RAddrOut(q)==rs || (RAddrOut(q)==rt && opcode in {0x00,0x2B,0x04})).
  - InReady = (!OutValid || OutReady) && !hazard.
  - When hazard && OutReady, OutValid goes to 0 next cycle (one bubble). The instruction is then accepted on the following cycle.
- Stall: OutValid && !OutReady holds every output register stable.
- Flush:
  - Flush has priority. OutValid is 0 the next cycle.
  - An instruction accepted in the same cycle as Flush is discarded; the handshake still completes.
  - A bubble is never inserted for a flushed load.
- If OutValid=0, all control bits are 0 (bubble = NOP); data fields are don't-care.
- Reset (asynchronous, nReset low): all output registers clear to 0, all registers in the file clear to 0, OutValid=0. Reset mid-handshake drops the in-flight instruction.

Test Plan:
- Reset, then ADDI r1,r0,0xFFFF (0x2001FFFF) with OutReady=1 -> next cycle OutValid=1, ImmData=0xFFFFFFFF, RAddrOut=1, ALUSrc=RegWriteOut=1, ALUfunc=0x20.
- LUI r2,0x1234 -> ImmData=0x12340000. Write-back RegWriteIn=1, RAddrIn=3, RData=0xDEADBEEF in the same cycle that ADD r4,r3,r0 is accepted -> RsData=0xDEADBEEF. Write to r0 -> r0 reads 0.
- LW r5,0(r0) followed by ADD r6,r5,r5 -> InReady=0 for one cycle, one OutValid=0 bubble, ADD issues in the next cycle. LW r5 followed by ADDI r6,r7,1 -> no bubble.
- OutReady held low for 3 cycles with InValid=1 -> outputs stable, InReady=0. Release -> next instruction issues, none lost or duplicated.
- Flush asserted while a BEQ is in the output register and SW is being accepted -> next cycle OutValid=0, all control bits 0, SW dropped.
- nReset pulsed low mid-stream -> all outputs 0 immediately, previously written registers read 0. DATA_W=64, NREGS=16 build repeats the ADDI and LUI cases with 64-bit sign extension.
